// File: rtl/booth2_code_serializer.sv
// Radix-4 Booth encoder for the multiplier operand: captures B and emits its
// WIDTH/2 overlapping 3-bit codes LSB group first, one per code handshake.
module booth2_code_serializer #(
  parameter int WIDTH = 16,
  localparam int NCODE = WIDTH / 2,
  localparam int IDXW = (NCODE > 1) ? $clog2(NCODE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [2:0]       code,
  output logic [IDXW-1:0]  code_idx,
  output logic             code_last,
  output logic             code_neg,
  output logic             code_zero
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCODE - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH:0]  sreg;
  logic [WIDTH:0]  sreg_nxt;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_nxt;
  logic            at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (in_valid) begin
          // Appended zero is the implicit b[-1] of the first group.
          sreg_nxt  = {B, 1'b0};
          idx_nxt   = '0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (code_ready) begin
          if (at_last) begin
            state_nxt = IDLE;
          end else begin
            sreg_nxt = {sreg[WIDTH], sreg[WIDTH], sreg[WIDTH:2]};
            idx_nxt  = idx + IDXW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign code_valid = (state == EMIT);
  assign code       = sreg[2:0];
  assign code_idx   = idx;
  assign code_last  = (state == EMIT) && at_last;
  assign code_neg   = code[2] & ~(code[1] & code[0]);
  assign code_zero  = (code == 3'b000) | (code == 3'b111);

endmodule

// File: tb/tb_booth2_code_serializer.sv
// Bench for booth2_code_serializer: fixed vector table, multi-cycle corner
// sequences and randomized operands checked by an arithmetic Booth model.
module tb_booth2_code_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] B = '0;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic [2:0]  code;
  logic [2:0]  code_idx;
  logic        code_last;
  logic        code_neg;
  logic        code_zero;

  int checks = 0;
  int errors = 0;

  booth2_code_serializer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .B(B),
    .code_valid(code_valid), .code_ready(code_ready), .code(code),
    .code_idx(code_idx), .code_last(code_last), .code_neg(code_neg),
    .code_zero(code_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic [23:0] codes;  // idx0 in bits [2:0]
    int          mode;   // 0 ready always, 1 pattern 1,0,0,1, 2 random
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Signed partial-product multiple selected by a Booth code.
  function automatic int pp_of(input logic [2:0] c);
    int v;
    v = 0;
    if (c[0]) v += 1;
    if (c[1]) v += 1;
    if (c[2]) v -= 2;
    return v;
  endfunction

  function automatic logic [2:0] booth_code(input logic [15:0] b, input int i);
    logic [16:0] e;
    e = {b, 1'b0};
    return {e[2*i+2], e[2*i+1], e[2*i]};
  endfunction

  task automatic run_operand(input logic [15:0] b, input int mode, input bit use_tab,
                             input logic [23:0] tab, input string tag);
    int n;
    int cyc;
    int p;
    longint acc;
    logic [2:0] exp_c;
    logic [2:0] prev_c;
    bit stalled;
    bit r;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    B = b;
    @(negedge clk);
    in_valid = 1'b0;
    B = ~b;
    n = 0; cyc = 0; p = 0; acc = 0; stalled = 0; prev_c = '0;
    while (n < 8 && cyc < 64) begin
      chk({tag, "_code_valid"}, code_valid, 1);
      if (code_valid) begin
        exp_c = use_tab ? tab[3*n +: 3] : booth_code(b, n);
        chk({tag, "_code"}, code, exp_c);
        chk({tag, "_idx"}, code_idx, n);
        chk({tag, "_last"}, code_last, (n == 7) ? 1 : 0);
        chk({tag, "_neg"}, code_neg, (pp_of(exp_c) < 0) ? 1 : 0);
        chk({tag, "_zero"}, code_zero, (pp_of(exp_c) == 0) ? 1 : 0);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
        if (stalled) chk({tag, "_stall_hold"}, code, prev_c);
        prev_c = code;
        case (mode)
          0: r = 1'b1;
          1: r = ((p % 4) == 0) || ((p % 4) == 3);
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        p++;
        code_ready = r;
        stalled = !r;
        if (r) begin
          acc += longint'(pp_of(code)) * (longint'(1) << (2 * n));
          n++;
        end
      end else begin
        code_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    code_ready = 1'b0;
    chk({tag, "_ncodes"}, n, 8);
    chk({tag, "_reconstruct"}, acc, longint'($signed(b)));
    chk({tag, "_done_valid"}, code_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    int acc_cyc[$];
    logic [2:0] got[$];
    int cyc;
    logic [23:0] t7fff;

    tbl[0] = '{16'h0001, 24'h000002, 0};
    tbl[1] = '{16'hFFFF, 24'hFFFFFE, 0};
    tbl[2] = '{16'h8000, 24'h800000, 0};
    tbl[3] = '{16'h5555, 24'h492492, 0};
    tbl[4] = '{16'h1234, 24'h08C390, 1};
    tbl[5] = '{16'h7FFF, 24'h7FFFFE, 2};
    tbl[6] = '{16'hAAAA, 24'hB6DB6C, 1};
    tbl[7] = '{16'h0002, 24'h00000C, 0};
    t7fff = 24'h7FFFFE;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_code_idx", code_idx, 0);
    chk("rst_code_last", code_last, 0);
    chk("rst_code_neg", code_neg, 0);
    chk("rst_code_zero", code_zero, 1);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) run_operand(tbl[k].b, tbl[k].mode, 1'b1, tbl[k].codes, $sformatf("vec%0d", k));

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    B = 16'h0003;
    code_ready = 1'b1;
    for (cyc = 0; cyc < 24; cyc++) begin
      if (in_ready && in_valid) begin
        acc_cyc.push_back(cyc);
      end else if (!in_ready) begin
        if (acc_cyc.size() == 1) B = 16'hAAAA;
        else if (acc_cyc.size() >= 2) in_valid = 1'b0;
      end
      if (code_valid) got.push_back(code);
      @(negedge clk);
    end
    in_valid = 1'b0;
    code_ready = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 9);
    chk("b2b_ncodes", got.size(), 16);
    if (got.size() == 16) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b_op0_code%0d", i), got[i], booth_code(16'h0003, i));
        chk($sformatf("b2b_op1_code%0d", i), got[8+i], tbl[6].codes[3*i +: 3]);
      end
    end

    // Reset during idx3 of B=7FFF
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    B = 16'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    code_ready = 1'b1;
    cyc = 0;
    while (!(code_valid && code_idx == 3'd3) && cyc < 20) begin
      chk($sformatf("rstmid_code%0d", code_idx), code, t7fff[3*code_idx +: 3]);
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reach_idx3", code_idx, 3);
    chk("rstmid_code3", code, t7fff[9 +: 3]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    code_ready = 1'b0;
    chk("rstmid_valid", code_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_idx", code_idx, 0);
    chk("rstmid_zero", code_zero, 1);
    run_operand(16'h0002, 0, 1'b1, tbl[7].codes, "after_rst");

    // Randomized operands with random consumer backpressure
    for (int k = 0; k < 2000; k++) begin
      run_operand(16'($urandom), 2, 1'b0, '0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
